autoshift_reg: RTL and testbench
================================

Name: autoshift_reg

Overview:
Parametrised shift-register unit for a PIO state machine. It can act as an ISR (input shift register, pushes to the RX FIFO) or an OSR (output shift register, pulls from the TX FIFO). It adds bit counting, thresholds, autopush/autopull, blocking and non-blocking FIFO handshakes, and stall reporting. It is instanced once per direction per state machine, is driven by the instruction-execute logic, and is clocked by the divided-clock enable.

Parameters:
WIDTH, 32, shift register width in bits; any value ≥2. CW = $clog2(WIDTH)+1 (local).
IS_INPUT, 1, 1 = ISR mode, 0 = OSR mode.

Ports:
clk  in  1  clock
reset  in  1  synchronous, active-high
penable  in  1  divided-clock enable; state updates only when 1
stalled  in  1  external stall (delay count); blocks all updates
shift_right  in  1  1 = shift right/LSB first, 0 = shift left
auto  in  1  autopush (ISR mode) or autopull (OSR mode) enable
threshold  in  CW-1  auto threshold; 0 encodes WIDTH
do_shift  in  1  IN/OUT strobe
shift_cnt  in  CW-1  bits per shift; 0 encodes WIDTH
din  in  WIDTH  ISR-mode shift source
push_req  in  1  explicit PUSH (ISR mode)
pull_req  in  1  explicit PULL (OSR mode)
block  in  1  explicit push/pull blocks on full/empty
fallback_data  in  WIDTH  OSR load value on non-blocking pull from an empty FIFO (X register)
fifo_in_data/fifo_in_valid  in  WIDTH/1  TX FIFO head (OSR mode)
fifo_in_ready  out  1  TX FIFO pop strobe
fifo_out_ready  in  1  RX FIFO not full (ISR mode)
fifo_out_data/fifo_out_valid  out  WIDTH/1  RX FIFO write
shift_out  out  WIDTH  OSR shifted-out bits, right-aligned, zero-extended (combinational)
sr  out  WIDTH  register contents
count  out  CW  bits shifted since last clear/load, 0..WIDTH
stall_out  out  1  current instruction must repeat (combinational)

Behaviour:
- Reset: sr=0. count=0 (ISR mode) or WIDTH (OSR mode, register empty). All strobes and stall_out = 0.
- act = penable & ~stalled & ~reset. With act=0, no state changes and all strobes and stall_out are 0.
- n = shift_cnt, or WIDTH if shift_cnt=0. T = threshold, or WIDTH if threshold=0.
- Shift right: sr <= {src[n-1:0], sr[WIDTH-1:n]}. Shift left: sr <= {sr[WIDTH-1-n:0], src[n-1:0]}. If n=WIDTH, sr <= src.
  - ISR mode: src = din.
  - OSR mode: src = 0 (zero-fill). shift_out = sr[n-1:0] (right) or sr[WIDTH-1:WIDTH-n] (left).
- count <= min(count+n, WIDTH). The count saturates and never wraps.
- Priority: reset > explicit push/pull > do_shift. When push_req or pull_req is asserted, do_shift is ignored.
- ISR mode:
  - push_req with fifo_out_ready=1: fifo_out_valid=1, fifo_out_data=sr; then sr <= 0, count <= 0.
  - push_req with fifo_out_ready=0 and block=1: stall_out=1, no change.
  - push_req with fifo_out_ready=0 and block=0: no write; sr and count still cleared.
  - Autopush: on do_shift with auto=1 and the post-shift count ≥ T:
    - If ready: write the post-shift value the same cycle; sr <= 0, count <= 0.
    - If not ready: stall_out=1 and no state change (the IN is replayed).
- OSR mode:
  - pull_req with fifo_in_valid=1: fifo_in_ready=1; sr <= fifo_in_data, count <= 0.
  - pull_req with fifo_in_valid=0 and block=1: stall_out=1.
  - pull_req with fifo_in_valid=0 and block=0: sr <= fallback_data, count <= 0.
  - Autopull: on any act cycle with auto=1, count ≥ T, fifo_in_valid=1, and no pull_req: pop and load, count <= 0.
  - do_shift while auto=1 and count ≥ T: stall_out=1 and no shift. The refill happens that cycle if data is present; the shift proceeds on the next act cycle.
- fifo strobes are single-cycle and only asserted when act=1. Reset mid-stall drops the stall immediately.

Optional Feature:
SHIFT_REG_LOAD_EN.
- Defined: adds ports load (in, 1) and load_data (in, WIDTH). When act & load: sr <= load_data, count <= 0 (MOV ISR/OSR). load has priority over push, pull and shift; it produces no FIFO strobe and no stall.
- Undefined: these ports do not exist and the behaviour is as above.

Test Plan:
1. ISR, WIDTH=32, shift_right=1, auto=0: four do_shift with shift_cnt=8 and din=0x11,0x22,0x33,0x44 → sr=0x44332211, count=32; a fifth shift keeps count=32.
2. ISR, auto=1, threshold=16, fifo_out_ready=1: two 8-bit shifts of 0xAB then 0xCD (left) → second cycle fifo_out_valid=1, data=0x0000ABCD; sr=0, count=0.
3. ISR, autopush hit with fifo_out_ready=0 for 3 cycles → stall_out=1 for 3 cycles, sr unchanged; write occurs on the cycle ready rises.
4. OSR, auto=1, threshold=0, reset state, fifo_in_valid=1, data 0xDEADBEEF: do_shift n=4 right → cycle 1 stall_out=1 and load; cycle 2 shift_out=0xF, count=4, sr=0x0DEADBEE.
5. OSR, pull_req, block=0, FIFO empty, fallback_data=0x5 → sr=0x5, count=0, fifo_in_ready=0, stall_out=0; same with block=1 → stall_out=1, sr unchanged.
6. penable=0 or stalled=1 with do_shift or push_req held → no state change, no strobes; reset asserted during a blocked push → sr=0, count=0, stall_out=0 next cycle.

Source files
------------

// File: rtl/autoshift_reg.sv
// Shift-register unit for a PIO state machine: ISR (autopush) or OSR (autopull) with bit counting and stall reporting.
// Optional MOV-load ports are enabled by defining SHIFT_REG_LOAD_EN.
module autoshift_reg #(
  parameter int unsigned WIDTH    = 32,
  parameter bit          IS_INPUT = 1'b1,
  localparam int unsigned CW      = $clog2(WIDTH) + 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             penable,
  input  logic             stalled,
  input  logic             shift_right,
  input  logic             auto,
  input  logic [CW-2:0]    threshold,
  input  logic             do_shift,
  input  logic [CW-2:0]    shift_cnt,
  input  logic [WIDTH-1:0] din,
  input  logic             push_req,
  input  logic             pull_req,
  input  logic             block,
  input  logic [WIDTH-1:0] fallback_data,
`ifdef SHIFT_REG_LOAD_EN
  input  logic             load,
  input  logic [WIDTH-1:0] load_data,
`endif
  input  logic [WIDTH-1:0] fifo_in_data,
  input  logic             fifo_in_valid,
  output logic             fifo_in_ready,
  input  logic             fifo_out_ready,
  output logic [WIDTH-1:0] fifo_out_data,
  output logic             fifo_out_valid,
  output logic [WIDTH-1:0] shift_out,
  output logic [WIDTH-1:0] sr,
  output logic [CW-1:0]    count,
  output logic             stall_out
);

  localparam logic [CW-1:0] WIDTH_C = CW'(WIDTH);

  logic [WIDTH-1:0]   sr_q, sr_d;
  logic [CW-1:0]      count_q, count_d;
  logic               act;
  logic [CW-1:0]      n, t;
  logic [WIDTH-1:0]   src, nmask, shifted;
  logic [2*WIDTH-1:0] cat_r;
  logic [CW:0]        count_sum;
  logic [CW-1:0]      count_sat;
  logic               load_hit;
  logic [WIDTH-1:0]   load_val;

`ifdef SHIFT_REG_LOAD_EN
  assign load_hit = load;
  assign load_val = load_data;
`else
  assign load_hit = 1'b0;
  assign load_val = '0;
`endif

  assign act = penable & ~stalled & ~reset;

  // Zero encodes a full-width shift/threshold; out-of-range codes also clamp to WIDTH.
  always_comb begin
    n = {1'b0, shift_cnt};
    if (shift_cnt == '0 || n > WIDTH_C) n = WIDTH_C;
    t = {1'b0, threshold};
    if (threshold == '0 || t > WIDTH_C) t = WIDTH_C;
  end

  // Right shift takes the low n bits of src into the top via a double-width funnel.
  always_comb begin
    src       = IS_INPUT ? din : '0;
    nmask     = ~({WIDTH{1'b1}} << n);
    cat_r     = {src, sr_q} >> n;
    shifted   = shift_right ? cat_r[WIDTH-1:0] : ((sr_q << n) | (src & nmask));
    count_sum = {1'b0, count_q} + {1'b0, n};
    count_sat = (count_sum > {1'b0, WIDTH_C}) ? WIDTH_C : count_sum[CW-1:0];
    if (IS_INPUT)
      shift_out = '0;
    else
      shift_out = shift_right ? (sr_q & nmask) : (sr_q >> (WIDTH_C - n));
  end

  always_comb begin
    sr_d           = sr_q;
    count_d        = count_q;
    fifo_in_ready  = 1'b0;
    fifo_out_valid = 1'b0;
    fifo_out_data  = sr_q;
    stall_out      = 1'b0;
    if (act) begin
      if (load_hit) begin
        sr_d    = load_val;
        count_d = '0;
      end else if (IS_INPUT) begin
        if (push_req) begin
          if (fifo_out_ready) begin
            fifo_out_valid = 1'b1;
            sr_d           = '0;
            count_d        = '0;
          end else if (block) begin
            stall_out = 1'b1;
          end else begin
            sr_d    = '0;
            count_d = '0;
          end
        end else if (do_shift) begin
          if (auto && count_sat >= t) begin
            if (fifo_out_ready) begin
              fifo_out_valid = 1'b1;
              fifo_out_data  = shifted;
              sr_d           = '0;
              count_d        = '0;
            end else begin
              stall_out = 1'b1;
            end
          end else begin
            sr_d    = shifted;
            count_d = count_sat;
          end
        end
      end else begin
        if (pull_req) begin
          if (fifo_in_valid) begin
            fifo_in_ready = 1'b1;
            sr_d          = fifo_in_data;
            count_d       = '0;
          end else if (block) begin
            stall_out = 1'b1;
          end else begin
            sr_d    = fallback_data;
            count_d = '0;
          end
        end else if (auto && count_q >= t) begin
          // Empty register: refill if possible, and replay any OUT on the next act cycle.
          if (fifo_in_valid) begin
            fifo_in_ready = 1'b1;
            sr_d          = fifo_in_data;
            count_d       = '0;
          end
          if (do_shift) stall_out = 1'b1;
        end else if (do_shift) begin
          sr_d    = shifted;
          count_d = count_sat;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      sr_q    <= '0;
      count_q <= IS_INPUT ? '0 : WIDTH_C;
    end else begin
      sr_q    <= sr_d;
      count_q <= count_d;
    end
  end

  assign sr    = sr_q;
  assign count = count_q;

endmodule

// File: tb/tb_autoshift_reg.sv
// Directed bench for autoshift_reg: one ISR and one OSR instance, FIFO traffic checked by a scoreboard monitor.
module tb_autoshift_reg;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic reset, penable, stalled;

  logic        i_right, i_auto, i_do_shift, i_push, i_pull, i_block, i_fi_valid, i_fo_ready;
  logic [4:0]  i_thr, i_cnt;
  logic [31:0] i_din, i_fb, i_fi_data;
  logic        i_fi_ready, i_fo_valid, i_stall;
  logic [31:0] i_fo_data, i_shout, i_sr;
  logic [5:0]  i_count;

  logic        o_right, o_auto, o_do_shift, o_push, o_pull, o_block, o_fi_valid, o_fo_ready;
  logic [4:0]  o_thr, o_cnt;
  logic [31:0] o_din, o_fb, o_fi_data;
  logic        o_fi_ready, o_fo_valid, o_stall;
  logic [31:0] o_fo_data, o_shout, o_sr;
  logic [5:0]  o_count;

  autoshift_reg #(.WIDTH(32), .IS_INPUT(1'b1)) u_isr (
    .clk(clk), .reset(reset), .penable(penable), .stalled(stalled),
    .shift_right(i_right), .auto(i_auto), .threshold(i_thr), .do_shift(i_do_shift),
    .shift_cnt(i_cnt), .din(i_din), .push_req(i_push), .pull_req(i_pull), .block(i_block),
    .fallback_data(i_fb), .fifo_in_data(i_fi_data), .fifo_in_valid(i_fi_valid),
    .fifo_in_ready(i_fi_ready), .fifo_out_ready(i_fo_ready), .fifo_out_data(i_fo_data),
    .fifo_out_valid(i_fo_valid), .shift_out(i_shout), .sr(i_sr), .count(i_count),
    .stall_out(i_stall)
  );

  autoshift_reg #(.WIDTH(32), .IS_INPUT(1'b0)) u_osr (
    .clk(clk), .reset(reset), .penable(penable), .stalled(stalled),
    .shift_right(o_right), .auto(o_auto), .threshold(o_thr), .do_shift(o_do_shift),
    .shift_cnt(o_cnt), .din(o_din), .push_req(o_push), .pull_req(o_pull), .block(o_block),
    .fallback_data(o_fb), .fifo_in_data(o_fi_data), .fifo_in_valid(o_fi_valid),
    .fifo_in_ready(o_fi_ready), .fifo_out_ready(o_fo_ready), .fifo_out_data(o_fo_data),
    .fifo_out_valid(o_fo_valid), .shift_out(o_shout), .sr(o_sr), .count(o_count),
    .stall_out(o_stall)
  );

  int unsigned n_checks = 0;
  int unsigned n_fail   = 0;
  logic [31:0] exp_push[$];
  logic [31:0] exp_pop[$];
  logic        pend_valid = 1'b0;
  logic [31:0] pend_data  = '0;

  task automatic chk(input string name, input logic [31:0] actual, input logic [31:0] expected);
    n_checks++;
    if (actual !== expected) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, actual, expected);
    end
  endtask

  // RX writes are compared against queued data; a TX pop must show up as the loaded sr one cycle later.
  always @(negedge clk) begin
    if (pend_valid) begin
      chk("osr_pop_load", o_sr, pend_data);
      pend_valid = 1'b0;
    end
    if (i_fo_valid) begin
      if (exp_push.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL isr_push: unexpected write 0x%08h expected none", i_fo_data);
      end else begin
        chk("isr_push", i_fo_data, exp_push.pop_front());
      end
    end
    if (o_fi_ready) begin
      if (exp_pop.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL osr_pop: unexpected pop got 1 expected 0");
      end else begin
        pend_data  = exp_pop.pop_front();
        pend_valid = 1'b1;
      end
    end
  end

  task automatic to_neg();
    @(negedge clk);
  endtask

  task automatic to_pos();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_isr();
    i_right = 0; i_auto = 0; i_do_shift = 0; i_push = 0; i_pull = 0; i_block = 0;
    i_fi_valid = 0; i_fo_ready = 0; i_thr = '0; i_cnt = '0; i_din = '0; i_fb = '0; i_fi_data = '0;
  endtask

  task automatic idle_osr();
    o_right = 0; o_auto = 0; o_do_shift = 0; o_push = 0; o_pull = 0; o_block = 0;
    o_fi_valid = 0; o_fo_ready = 0; o_thr = '0; o_cnt = '0; o_din = '0; o_fb = '0; o_fi_data = '0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] dins [4];
    dins[0] = 32'h11; dins[1] = 32'h22; dins[2] = 32'h33; dins[3] = 32'h44;
    reset = 1; penable = 1; stalled = 0;
    idle_isr();
    idle_osr();
    repeat (2) to_pos();
    reset = 0;
    to_neg();
    chk("rst_isr_sr", i_sr, 32'h0);
    chk("rst_isr_count", 32'(i_count), 32'd0);
    chk("rst_osr_sr", o_sr, 32'h0);
    chk("rst_osr_count", 32'(o_count), 32'd32);
    chk("rst_isr_stall", 32'(i_stall), 32'd0);
    chk("rst_osr_stall", 32'(o_stall), 32'd0);
    to_pos();

    // ISR right shifts, count saturates
    i_right = 1; i_cnt = 5'd8; i_do_shift = 1;
    for (int k = 0; k < 4; k++) begin
      i_din = dins[k];
      to_pos();
    end
    chk("isr_shr4_sr", i_sr, 32'h44332211);
    chk("isr_shr4_count", 32'(i_count), 32'd32);
    i_din = 32'h55;
    to_pos();
    chk("isr_sat_sr", i_sr, 32'h55443322);
    chk("isr_sat_count", 32'(i_count), 32'd32);
    i_do_shift = 0;

    // non-blocking push to full FIFO clears without write
    i_push = 1; i_fo_ready = 0; i_block = 0;
    to_neg();
    chk("isr_nbpush_stall", 32'(i_stall), 32'd0);
    to_pos();
    chk("isr_nbpush_sr", i_sr, 32'h0);
    chk("isr_nbpush_count", 32'(i_count), 32'd0);
    i_push = 0;

    // autopush at threshold 16, left shifts
    i_auto = 1; i_thr = 5'd16; i_fo_ready = 1; i_right = 0; i_do_shift = 1; i_din = 32'hAB;
    to_pos();
    chk("isr_ap1_sr", i_sr, 32'hAB);
    chk("isr_ap1_count", 32'(i_count), 32'd8);
    i_din = 32'hCD;
    exp_push.push_back(32'h0000ABCD);
    to_neg();
    chk("isr_ap2_stall", 32'(i_stall), 32'd0);
    to_pos();
    chk("isr_ap2_sr", i_sr, 32'h0);
    chk("isr_ap2_count", 32'(i_count), 32'd0);

    // autopush blocked by full FIFO for 3 cycles
    i_fo_ready = 0; i_din = 32'h12;
    to_pos();
    chk("isr_apb0_sr", i_sr, 32'h12);
    i_din = 32'h34;
    for (int k = 0; k < 3; k++) begin
      to_neg();
      chk("isr_apb_stall", 32'(i_stall), 32'd1);
      to_pos();
      chk("isr_apb_sr", i_sr, 32'h12);
      chk("isr_apb_count", 32'(i_count), 32'd8);
    end
    i_fo_ready = 1;
    exp_push.push_back(32'h00001234);
    to_neg();
    chk("isr_apr_stall", 32'(i_stall), 32'd0);
    to_pos();
    chk("isr_apr_sr", i_sr, 32'h0);
    chk("isr_apr_count", 32'(i_count), 32'd0);
    i_auto = 0;

    // explicit push beats do_shift
    i_din = 32'h77;
    to_pos();
    i_push = 1; i_din = 32'hFF;
    exp_push.push_back(32'h77);
    to_pos();
    chk("isr_push_sr", i_sr, 32'h0);
    chk("isr_push_count", 32'(i_count), 32'd0);
    i_push = 0;

    // penable / stalled gating, blocked push, reset mid-stall
    i_din = 32'h5A;
    to_pos();
    chk("isr_g0_sr", i_sr, 32'h5A);
    penable = 0; i_din = 32'hFF;
    repeat (2) begin
      to_neg();
      chk("isr_pen_stall", 32'(i_stall), 32'd0);
      to_pos();
      chk("isr_pen_sr", i_sr, 32'h5A);
    end
    penable = 1; stalled = 1; i_push = 1; i_fo_ready = 1;
    to_neg();
    chk("isr_stl_stall", 32'(i_stall), 32'd0);
    to_pos();
    chk("isr_stl_sr", i_sr, 32'h5A);
    chk("isr_stl_count", 32'(i_count), 32'd8);
    stalled = 0; i_fo_ready = 0; i_block = 1;
    to_neg();
    chk("isr_bpush_stall", 32'(i_stall), 32'd1);
    to_pos();
    chk("isr_bpush_sr", i_sr, 32'h5A);
    reset = 1;
    to_neg();
    chk("isr_rststall_stall", 32'(i_stall), 32'd0);
    to_pos();
    chk("isr_rststall_sr", i_sr, 32'h0);
    chk("isr_rststall_count", 32'(i_count), 32'd0);
    chk("osr_rst2_count", 32'(o_count), 32'd32);
    reset = 0;
    idle_isr();

    // OSR autopull from empty, then shift
    o_auto = 1; o_thr = '0; o_fi_valid = 1; o_fi_data = 32'hDEADBEEF;
    o_do_shift = 1; o_cnt = 5'd4; o_right = 1;
    exp_pop.push_back(32'hDEADBEEF);
    to_neg();
    chk("osr_apl_stall", 32'(o_stall), 32'd1);
    to_pos();
    chk("osr_apl_sr", o_sr, 32'hDEADBEEF);
    chk("osr_apl_count", 32'(o_count), 32'd0);
    o_fi_valid = 0;
    to_neg();
    chk("osr_sh_stall", 32'(o_stall), 32'd0);
    chk("osr_sh_out", o_shout, 32'hF);
    to_pos();
    chk("osr_sh_sr", o_sr, 32'h0DEADBEE);
    chk("osr_sh_count", 32'(o_count), 32'd4);
    o_right = 0; o_cnt = 5'd8; o_auto = 0;
    to_neg();
    chk("osr_shl_out", o_shout, 32'h0D);
    to_pos();
    chk("osr_shl_sr", o_sr, 32'hEADBEE00);
    chk("osr_shl_count", 32'(o_count), 32'd12);
    o_right = 1; o_cnt = '0;
    to_neg();
    chk("osr_full_out", o_shout, 32'hEADBEE00);
    to_pos();
    chk("osr_full_sr", o_sr, 32'h0);
    chk("osr_full_count", 32'(o_count), 32'd32);
    o_do_shift = 0;

    // pull from empty FIFO: fallback, then blocking stall
    o_pull = 1; o_block = 0; o_fb = 32'h5;
    to_neg();
    chk("osr_fb_stall", 32'(o_stall), 32'd0);
    to_pos();
    chk("osr_fb_sr", o_sr, 32'h5);
    chk("osr_fb_count", 32'(o_count), 32'd0);
    o_block = 1; o_fb = 32'h9;
    to_neg();
    chk("osr_bpull_stall", 32'(o_stall), 32'd1);
    to_pos();
    chk("osr_bpull_sr", o_sr, 32'h5);
    o_fi_valid = 1; o_fi_data = 32'hCAFEF00D; o_do_shift = 1; o_cnt = 5'd4;
    exp_pop.push_back(32'hCAFEF00D);
    to_neg();
    chk("osr_pull_stall", 32'(o_stall), 32'd0);
    to_pos();
    chk("osr_pull_sr", o_sr, 32'hCAFEF00D);
    chk("osr_pull_count", 32'(o_count), 32'd0);
    o_pull = 0; o_fi_valid = 0; o_block = 0;

    // autopull without an OUT once count reaches threshold 8
    o_auto = 1; o_thr = 5'd8; o_cnt = 5'd8;
    to_neg();
    chk("osr_t8_out", o_shout, 32'h0D);
    to_pos();
    chk("osr_t8_sr", o_sr, 32'h00CAFEF0);
    chk("osr_t8_count", 32'(o_count), 32'd8);
    o_do_shift = 0; o_fi_valid = 1; o_fi_data = 32'h12345678;
    exp_pop.push_back(32'h12345678);
    to_neg();
    chk("osr_idlepull_stall", 32'(o_stall), 32'd0);
    to_pos();
    chk("osr_idlepull_sr", o_sr, 32'h12345678);
    chk("osr_idlepull_count", 32'(o_count), 32'd0);
    idle_osr();

    repeat (2) to_pos();
    chk("push_queue_drained", 32'(exp_push.size()), 32'd0);
    chk("pop_queue_drained", 32'(exp_pop.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
